muldiv: RTL
===========

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A / dividend; driven from register file rdata1.
REQ-007 rs2_data  input  32  operand B / divisor; driven from register file rdata2.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  32  write-back value for register file wdata.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
- IDLE -> CALC: start=1.
- CALC -> DONE: after exactly 32 iteration cycles.
- DONE -> IDLE: unconditionally after one cycle.
REQ-012 On acceptance, funct3, rs1_data and rs2_data SHALL be latched; input changes during CALC/DONE SHALL have no effect.
REQ-013 start in CALC or DONE SHALL be ignored; it is not queued.
REQ-014 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-015 Latency: start high in cycle 0 (IDLE) -> busy high cycles 1..32 -> done high cycle 33 -> a new start is accepted no earlier than cycle 34.
REQ-016 result SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-017 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per CALC cycle, with a 64-bit product.
- MUL returns product[31:0].
- MULH: both operands signed; returns [63:32].
- MULHSU: rs1 signed, rs2 unsigned; returns [63:32].
- MULHU: both unsigned; returns [63:32].
REQ-018 Divide SHALL be restoring division on magnitudes, one quotient bit per CALC cycle.
- Quotient truncates toward zero.
- REM sign follows the dividend.
REQ-019 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rs1_data.
REQ-020 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-021 Negation of 0x80000000 during magnitude conversion SHALL be handled in 33-bit arithmetic without corrupting the result.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE and set busy=0, done=0, result=0, clearing all internal registers.
REQ-023 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never assert done.

Configuration
REQ-024 Macro MULDIV_FAST_EN:
- Defined: divide-by-zero, signed overflow, and MUL* with either operand zero SHALL skip CALC (IDLE -> DONE directly, done in cycle 1, busy never high), returning the REQ-019/020 values or 0.
- Undefined: every operation takes the full 32-cycle CALC path; results are identical in both builds.

Verification
REQ-025 MUL, rs1=7, rs2=6, start in cycle 0 -> busy cycles 1..32, done in cycle 33, result=0x0000002A.
REQ-026 rs1=rs2=0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF, MUL=0x00000001.
REQ-027 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFD; REM with same operands -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E.
REQ-028 DIV and REM with rs2=0, rs1=0x12345678 -> 0xFFFFFFFF and 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Done in cycle 33 without MULDIV_FAST_EN; in cycle 1 with it.
REQ-029 Start MUL 3*5, pulse start with rs1 and rs2 changed in cycle 10, assert reset in cycle 20 -> busy=0, done=0, result=0 from cycle 21; no done pulse. A fresh MUL 3*5 started after reset returns 0x0000000F.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between an RV32M requester and muldiv.
// The requester (master) drives the operation and operands; muldiv (slave)
// returns busy, a one-cycle done pulse and the write-back result.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rs1_data, rs2_data,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative RV32M multiply/divide unit.
// IDLE -> CALC (32 iteration cycles, one product/quotient bit each) -> DONE.
// Multiply is shift-add on operand magnitudes, divide is restoring division on
// magnitudes; signs are re-applied when the result is captured on DONE entry.
// Optional build macro MULDIV_FAST_EN: divide-by-zero, signed overflow and
// multiplies with a zero operand go straight from IDLE to DONE (no CALC).
// Results are identical with and without the macro.
module muldiv #(
   parameter int XLEN = 32
) (
   input  logic    clock,
   input  logic    reset,
   muldiv_if.slave bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_FAST_EN
   localparam bit FAST_EN = 1'b1;
`else
   localparam bit FAST_EN = 1'b0;
`endif

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Magnitude of a possibly negative operand. The negation is done one bit
   // wider so that 0x80000000 yields +2^31, which still fits the unsigned word.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            neg);
      logic [XLEN:0] wide;
      wide = neg ? ({(XLEN+1){1'b0}} - {1'b1, v}) : {1'b0, v};
      return wide[XLEN-1:0];
   endfunction

   function automatic logic [XLEN-1:0] cond_neg_w(input logic [XLEN-1:0] v,
                                                  input logic            neg);
      return neg ? ({XLEN{1'b0}} - v) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_d(input logic [2*XLEN-1:0] v,
                                                    input logic              neg);
      return neg ? ({(2*XLEN){1'b0}} - v) : v;
   endfunction

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op;
   logic [XLEN-1:0] hi;          // product high half / partial remainder
   logic [XLEN-1:0] lo;          // multiplier bits / dividend-then-quotient
   logic [XLEN-1:0] dvsr;        // multiplicand or divisor magnitude
   logic            neg_q;       // product or quotient must be negated
   logic            neg_r;       // remainder must be negated
   logic            special_q;
   logic [XLEN-1:0] special_val_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] result_q;

   // Operand decode at acceptance: signedness, magnitudes and corner cases.
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, mul_zero, special;
   logic [XLEN-1:0] special_val;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.funct3)
         F_MULH:       begin a_signed = 1'b1; b_signed = 1'b1; end
         F_MULHSU:     a_signed = 1'b1;
         F_DIV, F_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
         default:      ;
      endcase
      a_neg    = a_signed & bus.rs1_data[XLEN-1];
      b_neg    = b_signed & bus.rs2_data[XLEN-1];
      a_mag    = magnitude(bus.rs1_data, a_neg);
      b_mag    = magnitude(bus.rs2_data, b_neg);
      div_zero = bus.funct3[2] && (bus.rs2_data == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
      mul_zero = !bus.funct3[2] && ((bus.rs1_data == '0) || (bus.rs2_data == '0));
      special  = div_zero || div_ovf || mul_zero;
      special_val = '0;
      if (div_zero)
         special_val = bus.funct3[1] ? bus.rs1_data : '1;
      else if (div_ovf)
         special_val = bus.funct3[1] ? '0 : SMIN;
   end

   // One iteration step: shift-add for multiply, restore-or-subtract for divide.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, dvsr});
      div_diff  = div_shift[XLEN-1:0] - dvsr;
      if (op[2]) begin
         hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], div_ge};
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
      end
      prod   = {hi_nxt, lo_nxt};
      prod_s = cond_neg_d(prod, neg_q);
      case (op)
         F_MUL:                     final_res = prod_s[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             final_res = cond_neg_w(lo_nxt, neg_q);
         default:                   final_res = cond_neg_w(hi_nxt, neg_r);
      endcase
   end

   // Control FSM with datapath registers; busy/done/result are registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         op            <= '0;
         hi            <= '0;
         lo            <= '0;
         dvsr          <= '0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         special_q     <= 1'b0;
         special_val_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         result_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op            <= bus.funct3;
                  hi            <= '0;
                  lo            <= a_mag;
                  dvsr          <= b_mag;
                  neg_q         <= a_neg ^ b_neg;
                  neg_r         <= a_neg;
                  special_q     <= special;
                  special_val_q <= special_val;
                  cnt           <= '0;
                  if (FAST_EN && special) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     result_q <= special_val;
                  end else begin
                     state  <= CALC;
                     busy_q <= 1'b1;
                  end
               end
            end
            CALC: begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_ITER) begin
                  state    <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= special_q ? special_val_q : final_res;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
